// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-address, memory-return and decode-handshake bundle for fetch_queue
interface fetch_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]           pcF;
    logic [WIDTH-1:0]           instrF;
    logic                       imem_valid;
    logic                       redirect_valid;
    logic [WIDTH-1:0]           redirect_pc;
    logic                       deq_ready;
    logic                       validD;
    logic [WIDTH-1:0]           instrD;
    logic [WIDTH-1:0]           pcplus4D;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output pcF, validD, instrD, pcplus4D, count,
        input  instrF, imem_valid, redirect_valid, redirect_pc, deq_ready
    );

    modport slave (
        input  pcF, validD, instrD, pcplus4D, count,
        output instrF, imem_valid, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC and buffers {instr, pc+4} in a DEPTH-entry FIFO for decode
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc4 [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             valid;
    logic             deq;
    logic             enq;

    assign pc_plus4 = pc + WIDTH'(4);
    assign valid    = count != '0;
    assign deq      = valid & bus.deq_ready & ~bus.redirect_valid;
    // A dequeue from a full queue frees its slot for this cycle's fetch
    assign enq      = bus.imem_valid & ~bus.redirect_valid & ((count < FULL) | deq);

    // Control state: redirect flushes and re-points fetch, otherwise enq/deq advance pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.redirect_valid) begin
            pc    <= {bus.redirect_pc[WIDTH-1:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                pc   <= pc_plus4;
                tail <= tail + PW'(1);
            end
            if (deq)
                head <= head + PW'(1);
            if (enq != deq)
                count <= enq ? count + CW'(1) : count - CW'(1);
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[tail] <= bus.instrF;
            mem_pc4[tail]   <= pc_plus4;
        end
    end

    assign bus.pcF      = pc;
    assign bus.count    = count;
    assign bus.validD   = valid;
    assign bus.instrD   = valid ? mem_instr[head] : '0;
    assign bus.pcplus4D = valid ? mem_pc4[head] : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven scoreboard bench for fetch_queue
module tb_fetch_queue;
    localparam logic [31:0] RPC = 32'h0040_0000;

    typedef struct {
        logic        iv;
        logic        rv;
        logic        dr;
        logic [31:0] rpc;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    ent_t        sb[$];
    vec_t        vecs[$];

    fetch_queue_if #(.WIDTH(32), .DEPTH(4)) bus();

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5C3_0F0F;
    endfunction

    assign bus.instrF = mem(bus.pcF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " count"}, 32'(bus.count), 32'(sb.size()));
        chk({tag, " validD"}, 32'(bus.validD), 32'(sb.size() != 0));
        chk({tag, " pcF"}, bus.pcF, m_pc);
        if (sb.size() != 0) begin
            chk({tag, " instrD"}, bus.instrD, sb[0].instr);
            chk({tag, " pcplus4D"}, bus.pcplus4D, sb[0].pc4);
        end else begin
            chk({tag, " instrD"}, bus.instrD, 32'h0);
            chk({tag, " pcplus4D"}, bus.pcplus4D, 32'h0);
        end
    endtask

    task automatic step(input logic iv, input logic rv, input logic dr, input logic [31:0] rpc);
        logic d;
        logic e;
        ent_t nx;
        bus.imem_valid     = iv;
        bus.redirect_valid = rv;
        bus.deq_ready      = dr;
        bus.redirect_pc    = rpc;
        d = (sb.size() != 0) && dr && !rv;
        e = iv && !rv && ((sb.size() < 4) || d);
        nx.instr = mem(m_pc);
        nx.pc4   = m_pc + 32'd4;
        if (d) begin
            chk("deq instrD", bus.instrD, sb[0].instr);
            chk("deq pcplus4D", bus.pcplus4D, sb[0].pc4);
        end
        @(posedge clk);
        if (rv) begin
            sb.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (d) void'(sb.pop_front());
            if (e) begin
                sb.push_back(nx);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        check_state("step");
    endtask

    task automatic add(input logic iv, input logic rv, input logic dr, input logic [31:0] rpc, input int cnt);
        vec_t v;
        v.iv  = iv;
        v.rv  = rv;
        v.dr  = dr;
        v.rpc = rpc;
        v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        bus.imem_valid     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.deq_ready      = 1'b0;
        bus.redirect_pc    = 32'h0;
        m_pc               = RPC;

        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        reset = 1'b1;

        // streaming with decode always ready
        for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b1, 32'h0, 1);
        add(1'b0, 1'b0, 1'b1, 32'h0, 0);
        // fill, hold when full, drain in order
        for (int k = 1; k <= 4; k++) add(1'b1, 1'b0, 1'b0, 32'h0, k);
        add(1'b1, 1'b0, 1'b0, 32'h0, 4);
        for (int k = 3; k >= 0; k--) add(1'b0, 1'b0, 1'b1, 32'h0, k);
        // full with simultaneous enq/deq across pointer wrap
        for (int k = 1; k <= 4; k++) add(1'b1, 1'b0, 1'b0, 32'h0, k);
        for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 1'b1, 32'h0, 4);
        for (int k = 3; k >= 0; k--) add(1'b0, 1'b0, 1'b1, 32'h0, k);
        // redirect with 3 entries and misaligned target
        for (int k = 1; k <= 3; k++) add(1'b1, 1'b0, 1'b0, 32'h0, k);
        add(1'b1, 1'b1, 1'b1, 32'h0000_1003, 0);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1);
        // wait states 1,0,0,1
        add(1'b1, 1'b0, 1'b1, 32'h0, 1);
        add(1'b0, 1'b0, 1'b1, 32'h0, 0);
        add(1'b0, 1'b0, 1'b1, 32'h0, 0);
        add(1'b1, 1'b0, 1'b1, 32'h0, 1);
        add(1'b1, 1'b0, 1'b0, 32'h0, 2);
        add(1'b0, 1'b0, 1'b0, 32'h0, 2);
        // redirect during a wait state, then a redirect near the top of the address space
        add(1'b0, 1'b1, 1'b1, 32'h0000_2000, 0);
        add(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFA, 0);
        for (int k = 1; k <= 3; k++) add(1'b1, 1'b0, 1'b0, 32'h0, k);

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].rv, vecs[i].dr, vecs[i].rpc);
            chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].cnt));
            if (i == 32) begin
                chk("redirect pcF", bus.pcF, 32'h0000_1000);
                chk("redirect instrD", bus.instrD, 32'h0);
            end
            if (i == 33) chk("post-redirect pcplus4D", bus.pcplus4D, 32'h0000_1004);
        end
        chk("wrap pcF", bus.pcF, 32'h0000_0004);
        chk("wrap head pcplus4D", bus.pcplus4D, 32'hFFFF_FFFC);

        // asynchronous reset away from any clock edge with three entries held
        #3;
        reset = 1'b0;
        #1;
        sb.delete();
        m_pc = RPC;
        check_state("async reset");
        #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 32'h0);
        chk("restart pcF", bus.pcF, RPC + 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register PC/IF-ID front end of the 5-stage MIPS pipeline.
- Owns the fetch PC and drives instruction-memory fetches each cycle.
- Buffers fetched instructions, with their PC+4, in a DEPTH-entry FIFO. This decouples fetch from decode stalls and memory wait states.
- Decode consumes entries by valid/ready handshake. Taken branches and jumps resolved in decode redirect the PC and flush the queue.

Parameters:
- WIDTH, 32, instruction and address width in bits.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset; low two bits must be 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- pcF  output  WIDTH  current fetch address to instruction memory.
- instrF  input  WIDTH  instruction at pcF, combinational from memory.
- imem_valid  input  1  instrF is valid this cycle (0 = memory wait state).
- redirect_valid  input  1  taken branch or jump from decode.
- redirect_pc  input  WIDTH  target address for the redirect.
- deq_ready  input  1  decode accepts the head entry (~stallD).
- validD  output  1  head entry present.
- instrD  output  WIDTH  head instruction.
- pcplus4D  output  WIDTH  head entry's PC+4.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
Reset (reset=0, asynchronous):
- pcF=RESET_PC; head pointer, tail pointer and count = 0.
- validD=0, instrD=0, pcplus4D=0.
- Storage contents are don't-care.
- All state updates are on the rising clk edge; reset dominates any other input.

Definitions:
- deq = validD & deq_ready & ~redirect_valid.
- enq = imem_valid & ~redirect_valid & (count<DEPTH | deq).
- A dequeue from a full queue therefore frees the slot for an enqueue in the same cycle.

Enqueue (enq=1):
- Write {instrF, pcF+4} at the tail.
- Tail pointer increments modulo DEPTH.
- pcF <= pcF+4. Addition wraps modulo 2^WIDTH with no overflow flag.

No enqueue, no redirect:
- pcF holds.
- Covers memory wait (imem_valid=0) and full with no dequeue.

Dequeue (deq=1):
- Head pointer increments modulo DEPTH.

Count:
- count <= count + enq - deq.
- Simultaneous enq and deq leaves count unchanged.

Redirect (redirect_valid=1):
- Highest priority after reset.
- Next cycle: count=0, head=tail=0, pcF = {redirect_pc[WIDTH-1:2], 2'b00}.
- Misaligned low bits are silently cleared.
- No enqueue or dequeue occurs in the redirect cycle, even with deq_ready=1.
- The head entry presented during the redirect cycle is discarded. Decode must not latch it.

Outputs:
- validD = (count != 0).
- instrD and pcplus4D are the head entry when validD=1, and 0 otherwise (0 is the MIPS nop).
- Outputs are a combinational read of the registered storage and head pointer.
- Timing: fetch-to-decode latency is one cycle minimum. An instruction enqueued at edge N is visible at the head from edge N if the queue was empty.

Combinational paths:
- deq_ready -> enq (full case) and imem_valid -> pcF next-state are permitted.
- There is no combinational path from any input to validD, instrD, pcplus4D or count.

Invariants:
- count never exceeds DEPTH and never underflows.
- FIFO order is preserved across pointer wrap.
- Redirect mid-wait state is legal: the pending fetch is abandoned.
- Reset mid-operation discards all entries.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, imem_valid=1, deq_ready=1 for 3 cycles -> pcF steps 0x00400000, 0x00400004, 0x00400008; validD=1 from the second cycle; pcplus4D successively 0x00400004, 0x00400008.
- Fill: deq_ready=0, imem_valid=1, DEPTH=4 -> count reaches 4 after 4 cycles; pcF holds at RESET_PC+16; entries drain in order with deq_ready=1, count stepping down 4,3,2,1,0.
- Full with deq_ready=1 and imem_valid=1 -> count stays 4, pcF advances 4 per cycle, no entry lost or duplicated across 8 cycles (checks pointer wrap).
- Redirect: queue holding 3 entries, redirect_valid=1 with redirect_pc=32'h0000_1003 -> next cycle count=0, validD=0, instrD=0, pcF=32'h0000_1000; next enqueued entry has pcplus4D=32'h0000_1004.
- Wait states: imem_valid toggles 1,0,0,1 with deq_ready=1 -> pcF advances only on the cycles with imem_valid=1; validD tracks occupancy; no entry is captured during wait cycles.
- Asynchronous reset asserted mid-cycle with count=3 -> outputs clear immediately without a clock edge; pcF=RESET_PC.
